// File: rtl/c2h_pkt_buffer.sv
// c2h_pkt_buffer: store-and-forward packet buffer between the packet filter
// and the QDMA C2H stream. The input side never back-pressures. A packet is
// released downstream only after its last beat is stored. Packets that do not
// fit are dropped whole. Forwarded and dropped packets are counted.
//
// Ports:
//   axis_aclk, axis_areset      clock, async active-high reset
//   s_axis_*                    input stream from the packet filter
//   m_axis_*                    output stream to QDMA C2H (registered)
//   stat_clear                  pulse that zeroes both counters
//   stat_pkt_fwd/stat_pkt_drop  saturating packet counters
module c2h_pkt_buffer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic         axis_aclk,
  input  logic         axis_areset,
  input  logic         s_axis_tvalid,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic [47:0]  s_axis_tuser,
  output logic         s_axis_tready,
  output logic         m_axis_tvalid,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic [47:0]  m_axis_tuser,
  input  logic         m_axis_tready,
  input  logic         stat_clear,
  output logic [31:0]  stat_pkt_fwd,
  output logic [31:0]  stat_pkt_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 512;
  localparam int unsigned KW = 64;
  localparam int unsigned UW = 48;
  localparam int unsigned EW = DW + KW + 1 + UW;

  typedef enum logic {S_PASS = 1'b0, S_DROP = 1'b1} wr_state_e;

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          s_ready_q;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_q, out_d;
  logic [31:0]   stat_fwd_q, stat_fwd_d;
  logic [31:0]   stat_drop_q, stat_drop_d;

  logic [EW-1:0] mem [DEPTH];

  logic beat_acc;
  logic full;
  logic mem_we;
  logic rd_en;
  logic fwd_inc;
  logic drop_inc;

  assign beat_acc = s_axis_tvalid & s_ready_q;
  // Registered pointers only: a same-cycle read does not free room for a write.
  assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  // Only committed beats are visible to the read side.
  assign rd_en    = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || m_axis_tready);

  // Write-side FSM: store, commit on tlast, or rewind to the last commit on overflow.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    fwd_inc      = 1'b0;
    drop_inc     = 1'b0;
    if (beat_acc) begin
      case (state_q)
        S_PASS: begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis_tlast) begin
              commit_ptr_d = wr_ptr_q + PW'(1);
              fwd_inc      = 1'b1;
            end
          end else begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            if (!s_axis_tlast) state_d = S_DROP;
          end
        end
        S_DROP: begin
          if (s_axis_tlast) state_d = S_PASS;
        end
        default: state_d = S_PASS;
      endcase
    end
  end

  // Read side: refill the output register whenever it is empty or being consumed.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (rd_en) begin
      out_d       = mem[rd_ptr_q[AW-1:0]];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment.
  always_comb begin
    stat_fwd_d  = stat_fwd_q;
    stat_drop_d = stat_drop_q;
    if (stat_clear) begin
      stat_fwd_d  = '0;
      stat_drop_d = '0;
    end else begin
      if (fwd_inc && (stat_fwd_q != 32'hFFFF_FFFF))   stat_fwd_d  = stat_fwd_q + 32'd1;
      if (drop_inc && (stat_drop_q != 32'hFFFF_FFFF)) stat_drop_d = stat_drop_q + 32'd1;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q      <= S_PASS;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      s_ready_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      stat_fwd_q   <= '0;
      stat_drop_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      s_ready_q    <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      stat_fwd_q   <= stat_fwd_d;
      stat_drop_q  <= stat_drop_d;
    end
  end

  // Beat storage; contents are intentionally not reset.
  always_ff @(posedge axis_aclk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_q[UW+1+KW +: DW];
  assign m_axis_tkeep  = out_q[UW+1 +: KW];
  assign m_axis_tlast  = out_q[UW];
  assign m_axis_tuser  = out_q[UW-1:0];
  assign stat_pkt_fwd  = stat_fwd_q;
  assign stat_pkt_drop = stat_drop_q;

endmodule

// File: tb/tb_c2h_pkt_buffer.sv
// Self-checking bench for c2h_pkt_buffer: directed packet scenarios plus a
// randomized stress run. Expected beats are queued when a packet is sent and
// popped by an independent output monitor.
module tb_c2h_pkt_buffer;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned EW    = 625;
  localparam int unsigned CW    = 640;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_tvalid = 1'b0;
  logic [511:0] s_tdata  = '0;
  logic [63:0]  s_tkeep  = '0;
  logic         s_tlast  = 1'b0;
  logic [47:0]  s_tuser  = '0;
  logic         s_tready;
  logic         m_tvalid;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tlast;
  logic [47:0]  m_tuser;
  logic         m_tready = 1'b1;
  logic         stat_clear = 1'b0;
  logic [31:0]  stat_fwd;
  logic [31:0]  stat_drop;

  c2h_pkt_buffer #(.DEPTH(DEPTH)) dut (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .stat_clear    (stat_clear),
    .stat_pkt_fwd  (stat_fwd),
    .stat_pkt_drop (stat_drop)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int          delivered  = 0;
  int          kept_beats = 0;
  logic [31:0] fwd_exp  = '0;
  logic [31:0] drop_exp = '0;
  int          tready_mode = 1;  // 0: low, 1: high, 2: random

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: pops the scoreboard on each handshake and checks stall stability
  initial begin : monitor
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    logic [EW-1:0] hold_val;
    logic          hold_v;
    hold_v   = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("stall_stable", CW'({m_tvalid, cur}), CW'({1'b1, hold_val}));
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h required no beat", cur);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", CW'(cur), CW'(e));
          end
          delivered++;
        end
        hold_v   = m_tvalid && !m_tready;
        hold_val = cur;
      end
    end
  end

  // Sends one packet; fwd says whether the scenario expects it forwarded or dropped.
  task automatic send_pkt(input int len, input logic [47:0] user, input bit fwd,
                          input bit clr_on_last, input bit gaps);
    logic [EW-1:0] beats[$];
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 4) == 0)) begin
        s_tvalid = 1'b0;
        s_tlast  = 1'($urandom_range(0, 1));
        s_tdata[31:0] = $urandom();
        tick();
      end
      for (int k = 0; k < 16; k++) s_tdata[k*32 +: 32] = $urandom();
      s_tkeep    = {$urandom(), $urandom()};
      s_tlast    = (i == len - 1);
      s_tuser    = user;
      s_tvalid   = 1'b1;
      stat_clear = clr_on_last && s_tlast;
      check("s_tready", CW'(s_tready), CW'(1));
      beats.push_back({s_tdata, s_tkeep, s_tlast, s_tuser});
      if (s_tlast) begin
        if (fwd) begin
          foreach (beats[j]) exp_q.push_back(beats[j]);
          kept_beats += len;
        end
        if (clr_on_last) begin
          fwd_exp  = '0;
          drop_exp = '0;
        end else if (fwd) begin
          if (fwd_exp != 32'hFFFF_FFFF) fwd_exp++;
        end else begin
          if (drop_exp != 32'hFFFF_FFFF) drop_exp++;
        end
      end
      tick();
    end
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    stat_clear = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d beats still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (8) tick();
  endtask

  task automatic clear_stats();
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    fwd_exp  = '0;
    drop_exp = '0;
  endtask

  task automatic check_stats(input string name);
    check({name, "_fwd"},  CW'(stat_fwd),  CW'(fwd_exp));
    check({name, "_drop"}, CW'(stat_drop), CW'(drop_exp));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_s_tready"}, CW'(s_tready), CW'(0));
    check({name, "_m_tvalid"}, CW'(m_tvalid), CW'(0));
    check({name, "_m_beat"},   CW'({m_tdata, m_tkeep, m_tlast, m_tuser}), CW'(0));
    check({name, "_stat_fwd"}, CW'(stat_fwd), CW'(0));
    check({name, "_stat_drop"}, CW'(stat_drop), CW'(0));
  endtask

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("tready_before_edge", CW'(s_tready), CW'(0));
    tick();
    check("tready_after_edge", CW'(s_tready), CW'(1));
    repeat (2) tick();

    // Single packet: latency and contiguous output
    send_pkt(3, 48'h0000_00AB_CDEF, 1'b1, 1'b0, 1'b0);
    check("single_valid_at_tlast_edge", CW'(m_tvalid), CW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_valid_streaming", CW'(m_tvalid), CW'(1));
    end
    tick();
    check("single_valid_after", CW'(m_tvalid), CW'(0));
    wait_drain("single_drain");
    check_stats("single");

    // Overflow drop: 60-beat packet fits, following 10-beat packet does not
    clear_stats();
    tready_mode = 0;
    repeat (3) tick();
    send_pkt(60, 48'h1, 1'b1, 1'b0, 1'b0);
    send_pkt(10, 48'h2, 1'b0, 1'b0, 1'b0);
    check_stats("overflow");
    tready_mode = 1;
    wait_drain("overflow_drain");
    check_stats("overflow_after");

    // Oversize packet, then a 1-beat packet
    clear_stats();
    send_pkt(70, 48'h3, 1'b0, 1'b0, 1'b0);
    send_pkt(1, 48'h4, 1'b1, 1'b0, 1'b0);
    wait_drain("oversize_drain");
    check_stats("oversize");

    // Counter saturation
    clear_stats();
    force dut.stat_fwd_q = 32'hFFFF_FFFF;
    tick();
    release dut.stat_fwd_q;
    fwd_exp = 32'hFFFF_FFFF;
    check_stats("sat_preload");
    send_pkt(2, 48'h5, 1'b1, 1'b0, 1'b0);
    check_stats("sat_hold");
    // Clear coincident with a tlast beat
    send_pkt(3, 48'h6, 1'b1, 1'b1, 1'b0);
    check_stats("clear_vs_tlast");
    wait_drain("counter_drain");

    // Random stress with no overflow; occupancy bound keeps every packet fitting
    clear_stats();
    tready_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      int len;
      int cyc;
      len = int'($urandom_range(1, 20));
      cyc = 0;
      while ((kept_beats - delivered + len > int'(DEPTH)) && cyc < 2000) begin
        tick();
        cyc++;
      end
      if (cyc >= 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL stress_space: occupancy %0d did not drain, required <= %0d",
                 kept_beats - delivered, int'(DEPTH) - len);
      end
      send_pkt(len, {$urandom(), 16'($urandom())}, 1'b1, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain("stress_drain");
    check_stats("stress");

    // Mid-packet reset with a beat parked in the output register
    tready_mode = 0;
    repeat (3) tick();
    send_pkt(2, 48'h7, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    check("parked_valid", CW'(m_tvalid), CW'(1));
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tuser  = 48'h8;
    for (int k = 0; k < 16; k++) s_tdata[k*32 +: 32] = $urandom();
    tick();
    for (int k = 0; k < 16; k++) s_tdata[k*32 +: 32] = $urandom();
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midpkt_reset");
    s_tvalid = 1'b0;
    exp_q.delete();
    kept_beats = delivered;
    fwd_exp  = '0;
    drop_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midpkt_tready_before_edge", CW'(s_tready), CW'(0));
    tick();
    check("midpkt_tready_after_edge", CW'(s_tready), CW'(1));
    tready_mode = 1;
    send_pkt(2, 48'h9, 1'b1, 1'b0, 1'b0);
    wait_drain("midpkt_drain");
    check_stats("midpkt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
